// File: rtl/rx_cmd_pkg.sv
// Shared constants and types for the RX command parser: frame opcodes,
// command-op and error-code encodings, and the frame FSM state type.
package rx_cmd_pkg;

    // First byte of each frame selects the command type.
    localparam logic [7:0] OPC_REG_WR  = 8'hAA;
    localparam logic [7:0] OPC_REG_RD  = 8'hBB;
    localparam logic [7:0] OPC_ALU_OPS = 8'hCC;
    localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

    typedef enum logic [1:0] {
        OP_REG_WR  = 2'd0,
        OP_REG_RD  = 2'd1,
        OP_ALU_OPS = 2'd2,
        OP_ALU_NOP = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        ERR_BYTE     = 2'd0,
        ERR_OPCODE   = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_OVERRUN  = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GET_ADDR  = 3'd1,
        ST_GET_WDATA = 3'd2,
        ST_GET_OPA   = 3'd3,
        ST_GET_OPB   = 3'd4,
        ST_GET_FUN   = 3'd5
    } state_t;

endpackage

// File: rtl/rx_cmd_timeout.sv
// Inter-byte timeout: saturating idle counter with a synchronous clear.
// o_expired is high for the single cycle whose increment brings the count
// to TIMEOUT_CYC; a clear on that cycle suppresses it. TIMEOUT_CYC=0 disables.
module rx_cmd_timeout #(
    parameter int TMO_W       = 16,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_clear,
    output logic o_expired
);

    // Limit expressed in counter width; values beyond the counter range
    // are not meaningful and simply truncate.
    localparam logic [TMO_W-1:0] LIM = TMO_W'(TIMEOUT_CYC);

    logic [TMO_W-1:0] r_count;
    logic [TMO_W-1:0] w_count_nxt;

    // Next count: clear wins, otherwise increment and stick at all-ones.
    always_comb begin
        if (i_clear)
            w_count_nxt = '0;
        else if (r_count == '1)
            w_count_nxt = r_count;
        else
            w_count_nxt = r_count + TMO_W'(1);
    end

    // Counter register.
    always_ff @(posedge CLK) begin
        if (RST) r_count <= '0;
        else     r_count <= w_count_nxt;
    end

    assign o_expired = (TIMEOUT_CYC != 0) && !i_clear &&
                       (w_count_nxt == LIM) && (r_count != LIM);

endmodule

// File: rtl/rx_cmd_parser.sv
// RX command parser: assembles UART byte frames (AA/BB/CC/DD) into one
// decoded command held in an output register behind a valid/ready handshake.
// Optional statistics counters ERR_CNT/CMD_CNT when RX_CMD_STATS_EN is defined.
module rx_cmd_parser
    import rx_cmd_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int FUN_W       = 4,
    parameter int TMO_W       = 16,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        RX_P_DATA,
    input  logic              RX_D_VLD,
    input  logic              RX_PAR_ERR,
    input  logic              RX_STP_ERR,
    output logic              CMD_VALID,
    input  logic              CMD_READY,
    output logic [1:0]        CMD_OP,
    output logic [ADDR_W-1:0] CMD_ADDR,
    output logic [7:0]        CMD_WDATA,
    output logic [7:0]        CMD_OPA,
    output logic [7:0]        CMD_OPB,
    output logic [FUN_W-1:0]  CMD_FUN,
    output logic              ERR_PULSE,
    output logic [1:0]        ERR_CODE
`ifdef RX_CMD_STATS_EN
    ,
    output logic [7:0]        ERR_CNT,
    output logic [7:0]        CMD_CNT
`endif
);

    // Frame assembly state
    state_t            r_state, w_state_nxt;
    cmd_op_t           r_op, w_op_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_opa, r_opb;

    // Output holding register
    logic              r_valid;
    cmd_op_t           r_cmd_op;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [7:0]        r_cmd_wdata, r_cmd_opa, r_cmd_opb;
    logic [FUN_W-1:0]  r_cmd_fun;
    logic              r_err_pulse;
    err_code_t         r_err_code;

    logic              w_acc, w_byte_err, w_tmo, w_done, w_unk;
    logic              w_pop, w_load, w_ovr, w_err;
    err_code_t         w_err_code;
    logic [ADDR_W-1:0] w_new_addr;
    logic [7:0]        w_new_wdata, w_new_opa, w_new_opb;
    logic [FUN_W-1:0]  w_new_fun;

    assign w_acc      = RX_D_VLD && !RX_PAR_ERR && !RX_STP_ERR;
    assign w_byte_err = RX_D_VLD && (RX_PAR_ERR || RX_STP_ERR);

    rx_cmd_timeout #(
        .TMO_W       (TMO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .CLK       (CLK),
        .RST       (RST),
        .i_clear   (RX_D_VLD || (r_state == ST_IDLE)),
        .o_expired (w_tmo)
    );

    // Next state, frame opcode tracking, completion and unknown-opcode detect.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_done      = 1'b0;
        w_unk       = 1'b0;
        if (w_byte_err || w_tmo) begin
            w_state_nxt = ST_IDLE;
        end else if (w_acc) begin
            unique case (r_state)
                ST_IDLE: begin
                    case (RX_P_DATA)
                        OPC_REG_WR:  begin w_state_nxt = ST_GET_ADDR; w_op_nxt = OP_REG_WR;  end
                        OPC_REG_RD:  begin w_state_nxt = ST_GET_ADDR; w_op_nxt = OP_REG_RD;  end
                        OPC_ALU_OPS: begin w_state_nxt = ST_GET_OPA;  w_op_nxt = OP_ALU_OPS; end
                        OPC_ALU_NOP: begin w_state_nxt = ST_GET_FUN;  w_op_nxt = OP_ALU_NOP; end
                        default:     w_unk = 1'b1;
                    endcase
                end
                ST_GET_ADDR: begin
                    if (r_op == OP_REG_WR) begin
                        w_state_nxt = ST_GET_WDATA;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done      = 1'b1;
                    end
                end
                ST_GET_OPA: w_state_nxt = ST_GET_OPB;
                ST_GET_OPB: w_state_nxt = ST_GET_FUN;
                ST_GET_WDATA, ST_GET_FUN: begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Completed command from captured bytes plus the final byte; unused fields 0.
    always_comb begin
        w_new_addr  = '0;
        w_new_wdata = '0;
        w_new_opa   = '0;
        w_new_opb   = '0;
        w_new_fun   = '0;
        unique case (r_op)
            OP_REG_WR:  begin w_new_addr = r_addr; w_new_wdata = RX_P_DATA; end
            OP_REG_RD:  w_new_addr = RX_P_DATA[ADDR_W-1:0];
            OP_ALU_OPS: begin
                w_new_opa = r_opa;
                w_new_opb = r_opb;
                w_new_fun = RX_P_DATA[FUN_W-1:0];
            end
            default:    w_new_fun = RX_P_DATA[FUN_W-1:0];
        endcase
    end

    // FSM state register and intermediate byte capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_op    <= OP_REG_WR;
            r_addr  <= '0;
            r_opa   <= '0;
            r_opb   <= '0;
        end else begin
            // NOTE: non-blocking so all registers see pre-edge values.
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            if (w_acc) begin
                case (r_state)
                    ST_GET_ADDR: r_addr <= RX_P_DATA[ADDR_W-1:0];
                    ST_GET_OPA:  r_opa  <= RX_P_DATA;
                    ST_GET_OPB:  r_opb  <= RX_P_DATA;
                    default:     ;
                endcase
            end
        end
    end

    assign w_pop  = r_valid && CMD_READY;
    assign w_load = w_done && (!r_valid || CMD_READY);
    assign w_ovr  = w_done && r_valid && !CMD_READY;

    // Single error event per cycle, highest priority first.
    always_comb begin
        w_err      = 1'b1;
        w_err_code = r_err_code;
        if (w_byte_err)  w_err_code = ERR_BYTE;
        else if (w_ovr)  w_err_code = ERR_OVERRUN;
        else if (w_unk)  w_err_code = ERR_OPCODE;
        else if (w_tmo)  w_err_code = ERR_TIMEOUT;
        else             w_err      = 1'b0;
    end

    // Output holding register, valid flag and error strobe/code.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid     <= 1'b0;
            r_cmd_op    <= OP_REG_WR;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_cmd_opa   <= '0;
            r_cmd_opb   <= '0;
            r_cmd_fun   <= '0;
            r_err_pulse <= 1'b0;
            r_err_code  <= ERR_BYTE;
        end else begin
            if (w_load) begin
                r_valid     <= 1'b1;
                r_cmd_op    <= r_op;
                r_cmd_addr  <= w_new_addr;
                r_cmd_wdata <= w_new_wdata;
                r_cmd_opa   <= w_new_opa;
                r_cmd_opb   <= w_new_opb;
                r_cmd_fun   <= w_new_fun;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
            r_err_pulse <= w_err;
            r_err_code  <= w_err_code;
        end
    end

    assign CMD_VALID = r_valid;
    assign CMD_OP    = r_cmd_op;
    assign CMD_ADDR  = r_cmd_addr;
    assign CMD_WDATA = r_cmd_wdata;
    assign CMD_OPA   = r_cmd_opa;
    assign CMD_OPB   = r_cmd_opb;
    assign CMD_FUN   = r_cmd_fun;
    assign ERR_PULSE = r_err_pulse;
    assign ERR_CODE  = r_err_code;

`ifdef RX_CMD_STATS_EN
    logic [7:0] r_err_cnt, r_cmd_cnt;

    // Saturating error and transfer counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err_cnt <= '0;
            r_cmd_cnt <= '0;
        end else begin
            if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            if (w_pop && r_cmd_cnt != 8'hFF) r_cmd_cnt <= r_cmd_cnt + 8'd1;
        end
    end

    assign ERR_CNT = r_err_cnt;
    assign CMD_CNT = r_cmd_cnt;
`endif

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Directed testbench for rx_cmd_parser. A default-timeout instance carries the
// frame tests; a second instance with TIMEOUT_CYC=8 shares the same inputs and
// is used for the timeout scenarios.
module tb_rx_cmd_parser;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] rx_data;
    logic       rx_vld, rx_par, rx_stp, cmd_ready;

    logic       cmd_valid, err_pulse;
    logic [1:0] cmd_op, err_code;
    logic [3:0] cmd_addr, cmd_fun;
    logic [7:0] cmd_wdata, cmd_opa, cmd_opb;

    logic       t_valid, t_err_pulse;
    logic [1:0] t_op, t_err_code;
    logic [3:0] t_addr, t_fun;
    logic [7:0] t_wdata, t_opa, t_opb;

`ifdef RX_CMD_STATS_EN
    logic [7:0] err_cnt, cmd_cnt, t_err_cnt, t_cmd_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int err_seen = 0;
    int xfer_cnt = 0;

    rx_cmd_parser dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(rx_data), .RX_D_VLD(rx_vld),
        .RX_PAR_ERR(rx_par), .RX_STP_ERR(rx_stp), .CMD_VALID(cmd_valid),
        .CMD_READY(cmd_ready), .CMD_OP(cmd_op), .CMD_ADDR(cmd_addr),
        .CMD_WDATA(cmd_wdata), .CMD_OPA(cmd_opa), .CMD_OPB(cmd_opb),
        .CMD_FUN(cmd_fun), .ERR_PULSE(err_pulse), .ERR_CODE(err_code)
`ifdef RX_CMD_STATS_EN
        , .ERR_CNT(err_cnt), .CMD_CNT(cmd_cnt)
`endif
    );

    rx_cmd_parser #(.TIMEOUT_CYC(8)) dut_t (
        .CLK(CLK), .RST(RST), .RX_P_DATA(rx_data), .RX_D_VLD(rx_vld),
        .RX_PAR_ERR(rx_par), .RX_STP_ERR(rx_stp), .CMD_VALID(t_valid),
        .CMD_READY(cmd_ready), .CMD_OP(t_op), .CMD_ADDR(t_addr),
        .CMD_WDATA(t_wdata), .CMD_OPA(t_opa), .CMD_OPB(t_opb),
        .CMD_FUN(t_fun), .ERR_PULSE(t_err_pulse), .ERR_CODE(t_err_code)
`ifdef RX_CMD_STATS_EN
        , .ERR_CNT(t_err_cnt), .CMD_CNT(t_cmd_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    // Mid-cycle observers: error strobes and handshake transfers of the main DUT.
    always @(negedge CLK) begin
        if (err_pulse === 1'b1) err_seen++;
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1) xfer_cnt++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [7:0] b, input logic par, input logic stp);
        rx_data = b;
        rx_vld  = 1'b1;
        rx_par  = par;
        rx_stp  = stp;
        step();
        rx_vld  = 1'b0;
        rx_par  = 1'b0;
        rx_stp  = 1'b0;
    endtask

    task automatic do_reset();
        RST    = 1'b1;
        rx_vld = 1'b0;
        step();
        step();
        RST    = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_opa, cmd_opb, cmd_fun, err_pulse, err_code} !== 38'd0) begin errors++; $display("FAIL reset_main: got %h want 0", {cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_opa, cmd_opb, cmd_fun, err_pulse, err_code}); end
        checks++; if ({t_valid, t_op, t_addr, t_wdata, t_opa, t_opb, t_fun, t_err_pulse, t_err_code} !== 38'd0) begin errors++; $display("FAIL reset_tmo: got %h want 0", {t_valid, t_op, t_addr, t_wdata, t_opa, t_opb, t_fun, t_err_pulse, t_err_code}); end
`ifdef RX_CMD_STATS_EN
        checks++; if ({err_cnt, cmd_cnt} !== 16'd0) begin errors++; $display("FAIL reset_stats: got %h want 0", {err_cnt, cmd_cnt}); end
`endif
    endtask

    task automatic test_reg_wr();
        int e0;
        e0 = err_seen;
        cmd_ready = 1'b1;
        send(8'hAA, 1'b0, 1'b0); idle(9);
        send(8'h05, 1'b0, 1'b0); idle(9);
        send(8'h3C, 1'b0, 1'b0);
        checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL wr_valid: got %b want 1", cmd_valid); end
        checks++; if (cmd_op !== 2'd0) begin errors++; $display("FAIL wr_op: got %0d want 0", cmd_op); end
        checks++; if (cmd_addr !== 4'd5) begin errors++; $display("FAIL wr_addr: got %0d want 5", cmd_addr); end
        checks++; if (cmd_wdata !== 8'h3C) begin errors++; $display("FAIL wr_wdata: got %h want 3c", cmd_wdata); end
        checks++; if ({cmd_opa, cmd_opb, cmd_fun} !== 20'd0) begin errors++; $display("FAIL wr_zero_fields: got %h want 0", {cmd_opa, cmd_opb, cmd_fun}); end
        step();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL wr_valid_drop: got %b want 0", cmd_valid); end
        checks++; if (err_seen !== e0) begin errors++; $display("FAIL wr_no_err: got %0d pulses want 0", err_seen - e0); end
    endtask

    task automatic test_alu_hold();
        int x0;
        cmd_ready = 1'b0;
        send(8'hCC, 1'b0, 1'b0); idle(1);
        send(8'h12, 1'b0, 1'b0); idle(1);
        send(8'h34, 1'b0, 1'b0); idle(1);
        send(8'h07, 1'b0, 1'b0);
        checks++; if ({cmd_valid, cmd_op, cmd_opa, cmd_opb, cmd_fun} !== {1'b1, 2'd2, 8'h12, 8'h34, 4'd7}) begin errors++; $display("FAIL alu_cmd: got %h want %h", {cmd_valid, cmd_op, cmd_opa, cmd_opb, cmd_fun}, {1'b1, 2'd2, 8'h12, 8'h34, 4'd7}); end
        checks++; if ({cmd_addr, cmd_wdata} !== 12'd0) begin errors++; $display("FAIL alu_zero_fields: got %h want 0", {cmd_addr, cmd_wdata}); end
        x0 = xfer_cnt;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++; if ({cmd_valid, cmd_op, cmd_opa, cmd_opb, cmd_fun} !== {1'b1, 2'd2, 8'h12, 8'h34, 4'd7}) begin errors++; $display("FAIL alu_hold[%0d]: got %h want %h", i, {cmd_valid, cmd_op, cmd_opa, cmd_opb, cmd_fun}, {1'b1, 2'd2, 8'h12, 8'h34, 4'd7}); end
        end
        cmd_ready = 1'b1;
        step();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL alu_valid_drop: got %b want 0", cmd_valid); end
        checks++; if (xfer_cnt - x0 !== 1) begin errors++; $display("FAIL alu_single_xfer: got %0d want 1", xfer_cnt - x0); end
    endtask

    task automatic test_unknown_opcode();
        cmd_ready = 1'b1;
        send(8'h55, 1'b0, 1'b0);
        checks++; if ({err_pulse, err_code, cmd_valid} !== {1'b1, 2'd1, 1'b0}) begin errors++; $display("FAIL unk_err: got %b want 1010", {err_pulse, err_code, cmd_valid}); end
        step();
        checks++; if ({err_pulse, err_code} !== {1'b0, 2'd1}) begin errors++; $display("FAIL unk_code_hold: got %b want 001", {err_pulse, err_code}); end
        send(8'hDD, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0);
        checks++; if ({cmd_valid, cmd_op, cmd_fun} !== {1'b1, 2'd3, 4'd3}) begin errors++; $display("FAIL nop_cmd: got %h want %h", {cmd_valid, cmd_op, cmd_fun}, {1'b1, 2'd3, 4'd3}); end
        checks++; if ({cmd_addr, cmd_wdata, cmd_opa, cmd_opb} !== 28'd0) begin errors++; $display("FAIL nop_zero_fields: got %h want 0", {cmd_addr, cmd_wdata, cmd_opa, cmd_opb}); end
        step();
    endtask

    task automatic test_byte_error();
        cmd_ready = 1'b1;
        send(8'hAA, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        send(8'h77, 1'b1, 1'b0);
        checks++; if ({err_pulse, err_code, cmd_valid} !== {1'b1, 2'd0, 1'b0}) begin errors++; $display("FAIL par_err: got %b want 1000", {err_pulse, err_code, cmd_valid}); end
        step();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL par_no_cmd: got %b want 0", cmd_valid); end
        send(8'hBB, 1'b0, 1'b0);
        send(8'h09, 1'b0, 1'b0);
        checks++; if ({cmd_valid, cmd_op, cmd_addr, cmd_wdata} !== {1'b1, 2'd1, 4'd9, 8'h00}) begin errors++; $display("FAIL rd_after_par: got %h want %h", {cmd_valid, cmd_op, cmd_addr, cmd_wdata}, {1'b1, 2'd1, 4'd9, 8'h00}); end
        step();
        // A stop error on a valid opcode byte must not start a frame.
        send(8'hAA, 1'b0, 1'b1);
        checks++; if ({err_pulse, err_code} !== {1'b1, 2'd0}) begin errors++; $display("FAIL stp_err: got %b want 100", {err_pulse, err_code}); end
        send(8'hBB, 1'b0, 1'b0);
        send(8'h07, 1'b0, 1'b0);
        checks++; if ({cmd_valid, cmd_op, cmd_addr} !== {1'b1, 2'd1, 4'd7}) begin errors++; $display("FAIL rd_after_stp: got %h want %h", {cmd_valid, cmd_op, cmd_addr}, {1'b1, 2'd1, 4'd7}); end
        step();
    endtask

    task automatic test_timeout();
        cmd_ready = 1'b1;
        idle(20);
        send(8'hBB, 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++; if (t_err_pulse !== 1'b0) begin errors++; $display("FAIL tmo_early[%0d]: got %b want 0", k, t_err_pulse); end
        end
        step();
        checks++; if ({t_err_pulse, t_err_code} !== {1'b1, 2'd2}) begin errors++; $display("FAIL tmo_fire: got %b want 110", {t_err_pulse, t_err_code}); end
        send(8'h04, 1'b0, 1'b0);
        checks++; if ({t_err_pulse, t_err_code, t_valid} !== {1'b1, 2'd1, 1'b0}) begin errors++; $display("FAIL tmo_late_byte: got %b want 1010", {t_err_pulse, t_err_code, t_valid}); end
        checks++; if ({cmd_valid, cmd_op, cmd_addr, err_pulse} !== {1'b1, 2'd1, 4'd4, 1'b0}) begin errors++; $display("FAIL notmo_default: got %h want %h", {cmd_valid, cmd_op, cmd_addr, err_pulse}, {1'b1, 2'd1, 4'd4, 1'b0}); end
        idle(2);
        // A byte arriving on the expiry cycle completes the frame instead.
        send(8'hBB, 1'b0, 1'b0);
        idle(7);
        send(8'h06, 1'b0, 1'b0);
        checks++; if ({t_err_pulse, t_valid, t_op, t_addr} !== {1'b0, 1'b1, 2'd1, 4'd6}) begin errors++; $display("FAIL tmo_byte_wins: got %h want %h", {t_err_pulse, t_valid, t_op, t_addr}, {1'b0, 1'b1, 2'd1, 4'd6}); end
        step();
    endtask

    task automatic test_reset_mid_frame();
        cmd_ready = 1'b1;
        send(8'hAA, 1'b0, 1'b0);
        send(8'h07, 1'b0, 1'b0);
        do_reset();
        send(8'h3C, 1'b0, 1'b0);
        checks++; if ({err_pulse, err_code, cmd_valid} !== {1'b1, 2'd1, 1'b0}) begin errors++; $display("FAIL rst_mid_frame: got %b want 1010", {err_pulse, err_code, cmd_valid}); end
        step();
    endtask

    task automatic test_overrun();
        do_reset();
        cmd_ready = 1'b0;
        send(8'hDD, 1'b0, 1'b0);
        send(8'h01, 1'b0, 1'b0);
        checks++; if ({cmd_valid, cmd_op, cmd_fun} !== {1'b1, 2'd3, 4'd1}) begin errors++; $display("FAIL ovr_first: got %h want %h", {cmd_valid, cmd_op, cmd_fun}, {1'b1, 2'd3, 4'd1}); end
        send(8'hDD, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        checks++; if ({err_pulse, err_code} !== {1'b1, 2'd3}) begin errors++; $display("FAIL ovr_err: got %b want 111", {err_pulse, err_code}); end
        step();
        checks++; if ({cmd_valid, cmd_fun, err_pulse} !== {1'b1, 4'd1, 1'b0}) begin errors++; $display("FAIL ovr_held: got %h want %h", {cmd_valid, cmd_fun, err_pulse}, {1'b1, 4'd1, 1'b0}); end
`ifdef RX_CMD_STATS_EN
        checks++; if ({err_cnt, cmd_cnt} !== {8'd1, 8'd0}) begin errors++; $display("FAIL ovr_stats: got %h want 0100", {err_cnt, cmd_cnt}); end
`endif
        cmd_ready = 1'b1;
        step();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept: got %b want 0", cmd_valid); end
`ifdef RX_CMD_STATS_EN
        checks++; if (cmd_cnt !== 8'd1) begin errors++; $display("FAIL ovr_cmd_cnt: got %0d want 1", cmd_cnt); end
`endif
    endtask

    task automatic test_back_to_back();
        int x0;
        cmd_ready = 1'b0;
        send(8'hDD, 1'b0, 1'b0);
        send(8'h05, 1'b0, 1'b0);
        checks++; if ({cmd_valid, cmd_fun} !== {1'b1, 4'd5}) begin errors++; $display("FAIL b2b_first: got %h want 15", {cmd_valid, cmd_fun}); end
        x0 = xfer_cnt;
        send(8'hDD, 1'b0, 1'b0);
        cmd_ready = 1'b1;
        send(8'h06, 1'b0, 1'b0);
        checks++; if ({cmd_valid, cmd_fun, err_pulse} !== {1'b1, 4'd6, 1'b0}) begin errors++; $display("FAIL b2b_reload: got %h want %h", {cmd_valid, cmd_fun, err_pulse}, {1'b1, 4'd6, 1'b0}); end
        step();
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", cmd_valid); end
        checks++; if (xfer_cnt - x0 !== 2) begin errors++; $display("FAIL b2b_xfers: got %0d want 2", xfer_cnt - x0); end
    endtask

    initial begin
        RST       = 1'b1;
        rx_data   = 8'h00;
        rx_vld    = 1'b0;
        rx_par    = 1'b0;
        rx_stp    = 1'b0;
        cmd_ready = 1'b0;
        test_reset();
        test_reg_wr();
        test_alu_hold();
        test_unknown_opcode();
        test_byte_error();
        test_timeout();
        test_reset_mid_frame();
        test_overrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_cmd_parser.md
Name: rx_cmd_parser

Overview:
- Downstream of the UART receiver. Consumes its byte stream (parallel data, data-valid pulse, parity/stop error flags).
- Assembles multi-byte command frames into one decoded command word.
- Presents the command to the system controller's execute side over a valid/ready handshake.
- Single clock domain. Sits after the RX-side data synchronizer, in the destination clock domain.

Parameters:
ADDR_W, 4, register-file address width; the address byte is truncated to its low ADDR_W bits.
FUN_W, 4, ALU function width; the function byte is truncated to its low FUN_W bits.
TMO_W, 16, width of the inter-byte timeout counter.
TIMEOUT_CYC, 5000, idle cycles allowed between bytes of one frame; 0 disables the timeout.

Ports:
CLK  in  1  system clock.
RST  in  1  reset. Synchronous, active-high.
RX_P_DATA  in  8  received byte; qualified by RX_D_VLD.
RX_D_VLD  in  1  one-cycle pulse per received byte.
RX_PAR_ERR  in  1  parity error of the current byte (level).
RX_STP_ERR  in  1  stop-bit error of the current byte (level).
CMD_VALID  out  1  decoded command available.
CMD_READY  in  1  consumer accepts the command.
CMD_OP  out  2  0=REG_WR, 1=REG_RD, 2=ALU_OPS, 3=ALU_NOP.
CMD_ADDR  out  ADDR_W  register address (REG_WR/REG_RD; 0 otherwise).
CMD_WDATA  out  8  write data (REG_WR; 0 otherwise).
CMD_OPA  out  8  ALU operand A (ALU_OPS; 0 otherwise).
CMD_OPB  out  8  ALU operand B (ALU_OPS; 0 otherwise).
CMD_FUN  out  FUN_W  ALU function (ALU_OPS/ALU_NOP; 0 otherwise).
ERR_PULSE  out  1  one-cycle error strobe.
ERR_CODE  out  2  0=byte error, 1=unknown opcode, 2=timeout, 3=overrun; holds its last value.

Behaviour:
- Frames, byte order:
  - 0xAA: addr, data
  - 0xBB: addr
  - 0xCC: A, B, fun
  - 0xDD: fun
- Byte accepted on a cycle with RX_D_VLD=1 and RX_PAR_ERR=0 and RX_STP_ERR=0.
- FSM states: IDLE, GET_ADDR, GET_WDATA, GET_OPA, GET_OPB, GET_FUN.
  - IDLE + valid opcode -> GET_ADDR (0xAA/0xBB), GET_OPA (0xCC), GET_FUN (0xDD).
  - IDLE + any other byte -> stay IDLE; ERR_PULSE with code 1.
  - GET_ADDR -> GET_WDATA for REG_WR; completes the frame for REG_RD.
  - GET_OPA -> GET_OPB -> GET_FUN.
  - GET_WDATA and GET_FUN complete the frame.
- Completion: the frame completes on the cycle its last byte is accepted. The FSM returns to IDLE next edge.
- Output holding register:
  - If empty, it loads on completion; CMD_VALID rises on the next edge (latency 1 cycle from the last RX_D_VLD).
  - If full and CMD_READY=0, the completed frame is dropped; ERR_PULSE with code 3; the register is unchanged.
  - If full and CMD_READY=1 in the same cycle, the pop and the load both occur with no overrun.
- Handshake:
  - Transfer when CMD_VALID & CMD_READY.
  - CMD_* stable while CMD_VALID=1 and not accepted.
  - CMD_VALID deasserts after a transfer unless reloaded that same cycle.
- Byte error: RX_D_VLD=1 together with RX_PAR_ERR|RX_STP_ERR in any state -> byte discarded, FSM to IDLE, ERR_PULSE code 0. This takes priority over opcode decode.
- Timeout:
  - Counter clears on every RX_D_VLD and while in IDLE; increments each cycle otherwise, saturating.
  - Reaching TIMEOUT_CYC in a non-IDLE state -> IDLE, partial frame discarded, ERR_PULSE code 2.
  - A byte arriving on that same cycle wins and the timeout does not fire.
- At most one ERR_PULSE per cycle. Priority when events coincide: byte error > overrun > unknown opcode > timeout.
- Reset values: state IDLE, CMD_VALID=0, all CMD_* =0, ERR_PULSE=0, ERR_CODE=0, counter=0. Reset mid-frame discards all partial data.

Optional Feature:
- Macro RX_CMD_STATS_EN.
- When defined, adds output ports ERR_CNT[7:0] and CMD_CNT[7:0].
  - ERR_CNT increments on every ERR_PULSE.
  - CMD_CNT increments on every CMD handshake transfer.
  - Both saturate at 255 and reset to 0.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Package rx_cmd_pkg holds:
  - opcode constants OPC_REG_WR=0xAA, OPC_REG_RD=0xBB, OPC_ALU_OPS=0xCC, OPC_ALU_NOP=0xDD
  - CMD_OP encodings
  - ERR_CODE encodings
  - FSM state encoding
- One sub-module: rx_cmd_timeout (saturating counter, clear input, expiry compare, TIMEOUT_CYC=0 disable).

Test Plan:
- Bytes AA,05,3C at 10-cycle spacing, CMD_READY=1 -> one cycle of CMD_VALID after the last byte; OP=0, ADDR=5, WDATA=0x3C; no ERR_PULSE.
- Bytes CC,12,34,07 with CMD_READY=0 for 20 cycles, then 1 -> CMD_VALID held with OP=2, OPA=0x12, OPB=0x34, FUN=7 stable; single transfer.
- Byte 0x55 in IDLE -> ERR_PULSE code 1; next frame DD,03 -> OP=3, FUN=3.
- AA,02 then RX_D_VLD with RX_PAR_ERR=1 -> ERR_PULSE code 0, no command; next BB,09 -> OP=1, ADDR=9.
- TIMEOUT_CYC=8: BB then 8 idle cycles -> ERR_PULSE code 2 on the 8th; the late 0x04 byte then gives ERR_PULSE code 1.
- CMD_READY=0: DD,01 then DD,02 -> second frame dropped with ERR_PULSE code 3; output still FUN=1. With RX_CMD_STATS_EN: ERR_CNT=1, and CMD_CNT=1 after accept.
